// File: rtl/cas_lock_seq_unit.sv
// CAS-Lock output-corruption unit: serial key load, complementary AND/OR cascades, 2-stage XOR.
// Define CAS_MIRROR_EN to add the mirrored cascade pair (KC/KD) and widen the key to 4*N_IN.
module cas_lock_seq_unit #(
  parameter int unsigned     N_IN       = 32,
  parameter logic [N_IN-1:0] CHAIN_MASK = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_sin,
  input  logic            key_sin_valid,
  input  logic            key_commit,
  input  logic [N_IN-1:0] data_in,
  input  logic            orig_out,
  input  logic            in_valid,
  output logic            out_valid,
  output logic            out_bit,
  output logic            armed,
  output logic            key_err
);

`ifdef CAS_MIRROR_EN
  localparam int unsigned NumChains = 4;
`else
  localparam int unsigned NumChains = 2;
`endif
  localparam int unsigned KEY_W = NumChains * N_IN;
  localparam int unsigned CntW  = $clog2(KEY_W + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(KEY_W);
  localparam logic [CntW-1:0] CntMax  = CntW'(KEY_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StArmed} state_e;

  state_e                state_q, state_d;
  logic [KEY_W-1:0]      key_sr_q, key_sr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  key_err_q, key_err_d;
  logic                  flush;

  logic [NumChains-1:0]  chain, chain_s1_q;
  logic                  orig_s1_q, valid_s1_q, valid_s1_d;
  logic                  out_bit_q, out_valid_q, out_valid_d;
  logic                  casop;

  // Gate 1 is always AND; later gates pick AND/OR from CHAIN_MASK.
  function automatic logic cascade(input logic [N_IN-1:0] x);
    logic g;
    g = x[0] & x[1];
    for (int unsigned i = 2; i < N_IN; i++) begin
      g = CHAIN_MASK[i] ? (x[i] | g) : (x[i] & g);
    end
    return g;
  endfunction

  always_comb begin
    chain = '0;
    for (int unsigned k = 0; k < NumChains; k++) begin
      chain[k] = cascade(data_in ^ key_sr_q[k*N_IN +: N_IN]);
    end
  end

  always_comb begin
    state_d   = state_q;
    key_sr_d  = key_sr_q;
    cnt_d     = cnt_q;
    key_err_d = 1'b0;
    flush     = 1'b0;

    // Shift precedes commit so a same-cycle commit sees the updated count.
    if (key_sin_valid) begin
      key_sr_d = {key_sr_q[KEY_W-2:0], key_sin};
      if (state_q == StLoad) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = CntW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (key_sin_valid) state_d = StLoad;
      end
      StLoad: begin
        if (key_commit) begin
          if (cnt_d == CntFull) begin
            state_d = StArmed;
            cnt_d   = '0;
          end else begin
            state_d   = StIdle;
            key_err_d = 1'b1;
            key_sr_d  = '0;
            cnt_d     = '0;
          end
        end
      end
      StArmed: begin
        if (key_sin_valid) begin
          state_d = StLoad;
          flush   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    casop = chain_s1_q[0] & ~chain_s1_q[1];
`ifdef CAS_MIRROR_EN
    casop = casop ^ (~chain_s1_q[2] & chain_s1_q[3]);
`endif
  end

  // Rekeying kills in-flight data so no output is derived from the old key.
  assign valid_s1_d  = in_valid & (state_q == StArmed) & ~flush;
  assign out_valid_d = valid_s1_q & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      key_sr_q    <= '0;
      cnt_q       <= '0;
      key_err_q   <= 1'b0;
      chain_s1_q  <= '0;
      orig_s1_q   <= 1'b0;
      valid_s1_q  <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_sr_q    <= key_sr_d;
      cnt_q       <= cnt_d;
      key_err_q   <= key_err_d;
      chain_s1_q  <= chain;
      orig_s1_q   <= orig_out;
      valid_s1_q  <= valid_s1_d;
      out_bit_q   <= orig_s1_q ^ casop;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign armed     = (state_q == StArmed);
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_cas_lock_seq_unit.sv
// Self-checking bench for cas_lock_seq_unit (N_IN=4, CHAIN_MASK=4'b1100, no mirror).
module tb_cas_lock_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_sin = 1'b0;
  logic       key_sin_valid = 1'b0;
  logic       key_commit = 1'b0;
  logic [3:0] data_in = '0;
  logic       orig_out = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_valid, out_bit, armed, key_err;

  always #5 clk = ~clk;

  cas_lock_seq_unit #(
    .N_IN       (4),
    .CHAIN_MASK (4'b1100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_sin       (key_sin),
    .key_sin_valid (key_sin_valid),
    .key_commit    (key_commit),
    .data_in       (data_in),
    .orig_out      (orig_out),
    .in_valid      (in_valid),
    .out_valid     (out_valid),
    .out_bit       (out_bit),
    .armed         (armed),
    .key_err       (key_err)
  );

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Reference model: last 8 shifted bits, bits loaded since load began, mode flags,
  // and expected outputs indexed by the cycle they appear on.
  logic [7:0] key_m = '0;
  int         nbits_m = 0;
  bit         armed_m = 0, loading_m = 0, err_m = 0;
  bit         exp_v [0:4095];
  bit         exp_b [0:4095];

  // Mask 1100: g1 = x0&x1, g2 = x2|g1, g3 = x3|g2.
  function automatic bit chain(input logic [3:0] x);
    return x[3] | x[2] | (x[0] & x[1]);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    key_m = '0; nbits_m = 0; armed_m = 0; loading_m = 0; err_m = 0;
    for (int i = 0; i < 4096; i++) begin
      exp_v[i] = 0;
      exp_b[i] = 0;
    end
  endtask

  task automatic step(input logic sv, input logic sin, input logic cm, input logic iv,
                      input logic [3:0] d, input logic o);
    logic [3:0] ka, kb;
    bit was_loading;
    key_sin_valid = sv; key_sin = sin; key_commit = cm;
    in_valid = iv; data_in = d; orig_out = o;
    ka = key_m[3:0];
    kb = key_m[7:4];
    err_m = 0;
    was_loading = loading_m;
    exp_v[(cyc + 2) % 4096] = armed_m && iv;
    exp_b[(cyc + 2) % 4096] = o ^ (chain(d ^ ka) & ~chain(d ^ kb));
    if (sv) begin
      key_m = {key_m[6:0], sin};
      nbits_m = was_loading ? ((nbits_m < 9) ? nbits_m + 1 : 9) : 1;
      if (armed_m) begin
        armed_m = 0;
        exp_v[(cyc + 1) % 4096] = 0;
        exp_v[(cyc + 2) % 4096] = 0;
      end
    end
    if (was_loading && cm) begin
      loading_m = 0;
      if (nbits_m == 8) begin
        armed_m = 1;
      end else begin
        err_m = 1; key_m = '0; nbits_m = 0;
      end
    end else if (sv) begin
      loading_m = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("armed", armed, armed_m);
    chk("key_err", key_err, err_m);
    chk("out_valid", out_valid, exp_v[cyc % 4096]);
    if (exp_v[cyc % 4096]) chk("out_bit", out_bit, exp_b[cyc % 4096]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 0);
  endtask

  // Shift n bits of k MSB first; optionally raise commit with the last bit.
  task automatic load_key(input logic [15:0] k, input int n, input bit commit_last);
    for (int i = n - 1; i >= 0; i--) step(1, k[i], commit_last && (i == 0), 0, 4'h0, 0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    key_sin_valid = 0; key_commit = 0; in_valid = 0;
    #1;
    chk("rst_armed", armed, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bit", out_bit, 1'b0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("por_armed", armed, 1'b0);
    chk("por_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of a load.
    load_key(16'h00a5, 5, 0);
    do_reset();
    idle(2);

    // All-zero key, chains both 1 for 0011 -> CASOP 0, out = orig.
    load_key(16'h0000, 8, 0);
    step(0, 0, 1, 0, 4'h0, 0);
    step(0, 0, 0, 1, 4'b0011, 1);
    step(0, 0, 0, 0, 4'h0, 0);
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_out_bit", out_bit, 1'b1);
    idle(1);

    // KB = 0001, KA = 0000 -> chainA 1, chainB 0, CASOP 1, out inverted.
    load_key(16'h0010, 8, 0);
    step(0, 0, 1, 0, 4'h0, 0);
    step(0, 0, 0, 1, 4'b0011, 1);
    step(0, 0, 0, 0, 4'h0, 0);
    chk("t3_out_valid", out_valid, 1'b1);
    chk("t3_out_bit", out_bit, 1'b0);
    idle(1);

    // Short and over-long loads are rejected.
    load_key(16'h005a, 7, 0);
    step(0, 0, 1, 0, 4'h0, 0);
    chk("t4_short_err", key_err, 1'b1);
    idle(1);
    chk("t4_err_pulse", key_err, 1'b0);
    load_key(16'h01ff, 9, 0);
    step(0, 0, 1, 0, 4'h0, 0);
    chk("t4_long_err", key_err, 1'b1);
    idle(2);

    // Rekey while streaming drops everything in flight.
    load_key(16'h00c3, 8, 0);
    step(0, 0, 1, 0, 4'h0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 4'($urandom), 1'($urandom));
    step(1, 1, 0, 1, 4'($urandom), 1'($urandom));
    chk("t5_flush_valid", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 4'($urandom), 1'($urandom));
    step(0, 0, 1, 0, 4'h0, 0);
    idle(2);

    // Eighth bit and commit in the same cycle arm the unit.
    load_key(16'h0096, 8, 1);
    chk("t6_armed", armed, 1'b1);
    chk("t6_no_err", key_err, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 4'($urandom), 1'($urandom));

    // Randomised rounds: load of 7..9 bits, commit, stream; next load rekeys mid-stream.
    for (int r = 0; r < 60; r++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 7 : 9) : 8;
      for (int i = 0; i < n; i++) begin
        bit last;
        last = (i == n - 1);
        step(1, 1'($urandom), last && ($urandom_range(0, 1) == 1), 1'($urandom),
             4'($urandom), 1'($urandom));
      end
      if (loading_m) step(0, 0, 1, 1'($urandom), 4'($urandom), 1'($urandom));
      for (int i = 0; i < int'($urandom_range(2, 12)); i++) begin
        step(0, 0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
             4'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 9) == 0) begin
        do_reset();
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
